// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, opcode constants, branch offset helper.
package cpu_pkg;

   localparam int unsigned INSTR_W = 32;

   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StExec  = 2'd2,
      StHalt  = 2'd3
   } fetch_state_e;

   // Sign-extended word offset of a branch immediate, already scaled to bytes.
   function automatic logic [INSTR_W-1:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC datapath: pc+4, branch and jump targets, and the jump > branch > sequential mux.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] pc,
   input  logic [25:0]        instr_idx,
   input  logic               jump,
   input  logic               branch,
   output logic [INSTR_W-1:0] pc_plus4,
   output logic [INSTR_W-1:0] next_pc
);

   logic [INSTR_W-1:0] branch_target;
   logic [INSTR_W-1:0] jump_target;

   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + branch_offset(instr_idx[15:0]);
   assign jump_target   = {pc_plus4[31:28], instr_idx, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (branch) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, instruction register, halt state.
// Define IFETCH_RETIRE_CNT_EN to enable the retired-instruction counter.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [5:0]         op,
   output logic [5:0]         funct,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   input  logic               PCwrt,
   input  logic               jump,
   input  logic               branch,
   output logic               halted,
   output logic [31:0]        retired_cnt
);

   localparam logic [31:0] PcInit = {RESET_PC[31:2], 2'b00};

   fetch_state_e       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               req_q, req_d;
   logic               valid_q, valid_d;
   logic               halted_q, halted_d;
   logic [31:0]        next_pc;

   next_pc_calc u_next_pc_calc (
      .pc        (pc_q),
      .instr_idx (instr_q[25:0]),
      .jump      (jump),
      .branch    (branch),
      .pc_plus4  (pc_plus4),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = StExec;
            end
         end
         StExec: begin
            if (PCwrt) begin
               pc_d    = next_pc;
               state_d = StFetch;
            end else begin
               state_d = StHalt;
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
      // Status outputs are registered from the next state so they align with state_q.
      req_d    = (state_d == StFetch);
      valid_d  = (state_d == StExec);
      halted_d = (state_d == StHalt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pc_q     <= PcInit;
         instr_q  <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

`ifdef IFETCH_RETIRE_CNT_EN
   logic [31:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (state_q == StExec && PCwrt) begin
         retired_d = retired_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired_cnt = retired_q;
`else
   assign retired_cnt = '0;
`endif

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign op          = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign pc          = pc_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: sequential fetch, branch, jump priority, wait states,
// halt, and reset during a pending fetch.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        PCwrt;
   logic        jump;
   logic        branch;
   logic        halted;
   logic [31:0] retired_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] exp_retired;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .op          (op),
      .funct       (funct),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .PCwrt       (PCwrt),
      .jump        (jump),
      .branch      (branch),
      .halted      (halted),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   // Instruction memory contents.
   always_comb begin
      case (imem_addr)
         32'h0000_000C: imem_rdata = 32'h0800_0040;
         32'h0000_0100: imem_rdata = 32'h1000_FFFE;
         32'h0000_00FC: imem_rdata = 32'h0BFF_FFFF;
         32'h1000_0000: imem_rdata = 32'h0800_0040;
         32'h1000_0100: imem_rdata = 32'hFC00_0000;
         default:       imem_rdata = {6'h23, 10'h000, imem_addr[15:0]};
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in FETCH; leaves after the EXEC closing edge.
   task automatic fetch_exec(input logic [31:0] addr, input logic [31:0] word,
                             input logic j, input logic b, input logic w);
      check("fetch_req", {31'b0, imem_req}, 32'd1);
      check("fetch_addr", imem_addr, addr);
      check("fetch_valid", {31'b0, instr_valid}, 32'd0);
      imem_ack = 1'b1;
      tick();
      check("exec_valid", {31'b0, instr_valid}, 32'd1);
      check("exec_req", {31'b0, imem_req}, 32'd0);
      check("exec_instr", instr, word);
      check("exec_op", {26'b0, op}, {26'b0, word[31:26]});
      check("exec_funct", {26'b0, funct}, {26'b0, word[5:0]});
      check("exec_pc", pc, addr);
      check("exec_pc_plus4", pc_plus4, addr + 32'd4);
      imem_ack = 1'b0;
      jump     = j;
      branch   = b;
      PCwrt    = w;
      tick();
      jump   = 1'b0;
      branch = 1'b0;
      PCwrt  = 1'b1;
   endtask

   initial begin
`ifdef IFETCH_RETIRE_CNT_EN
      exp_retired = 32'd8;
`else
      exp_retired = 32'd0;
`endif
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      PCwrt    = 1'b1;
      jump     = 1'b0;
      branch   = 1'b0;
      #3;
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_retired", retired_cnt, 32'h0);

      @(posedge clk);
      #1 rst_n = 1'b1;
      check("idle_req", {31'b0, imem_req}, 32'd0);
      tick();

      fetch_exec(32'h0000_0000, 32'h8C00_0000, 1'b0, 1'b0, 1'b1);
      fetch_exec(32'h0000_0004, 32'h8C00_0004, 1'b0, 1'b0, 1'b1);
      fetch_exec(32'h0000_0008, 32'h8C00_0008, 1'b0, 1'b0, 1'b1);
      fetch_exec(32'h0000_000C, 32'h0800_0040, 1'b1, 1'b0, 1'b1);
      fetch_exec(32'h0000_0100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1);

      // Three wait states with ack low; controller inputs must be ignored in FETCH.
      jump   = 1'b1;
      branch = 1'b1;
      PCwrt  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wait_req", {31'b0, imem_req}, 32'd1);
         check("wait_addr", imem_addr, 32'h0000_00FC);
         check("wait_valid", {31'b0, instr_valid}, 32'd0);
         tick();
      end
      jump   = 1'b0;
      branch = 1'b0;
      PCwrt  = 1'b1;
      fetch_exec(32'h0000_00FC, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b1);
      fetch_exec(32'h0FFF_FFFC, 32'h8C00_FFFC, 1'b0, 1'b0, 1'b1);
      fetch_exec(32'h1000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1);
      fetch_exec(32'h1000_0100, 32'hFC00_0000, 1'b0, 1'b0, 1'b0);

      check("halt_halted", {31'b0, halted}, 32'd1);
      check("halt_retired", retired_cnt, exp_retired);
      PCwrt    = 1'b1;
      jump     = 1'b1;
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("halt_stay", {31'b0, halted}, 32'd1);
         check("halt_req", {31'b0, imem_req}, 32'd0);
         check("halt_valid", {31'b0, instr_valid}, 32'd0);
         check("halt_pc", pc, 32'h1000_0100);
         tick();
      end
      check("halt_retired_hold", retired_cnt, exp_retired);

      // Leave HALT via reset, then reset again while a fetch waits for ack.
      rst_n    = 1'b0;
      imem_ack = 1'b0;
      jump     = 1'b0;
      #1;
      check("rst2_halted", {31'b0, halted}, 32'd0);
      check("rst2_pc", pc, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      tick();
      check("pend_req", {31'b0, imem_req}, 32'd1);
      check("pend_addr", imem_addr, 32'h0);
      rst_n = 1'b0;
      #1;
      check("midrst_req", {31'b0, imem_req}, 32'd0);
      check("midrst_valid", {31'b0, instr_valid}, 32'd0);
      check("midrst_retired", retired_cnt, 32'h0);
      imem_ack = 1'b1;
      tick();
      check("late_ack_instr", instr, 32'h0);
      check("late_ack_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("restart_req", {31'b0, imem_req}, 32'd1);
      check("restart_addr", imem_addr, 32'h0);
      check("restart_instr", instr, 32'h0);
      tick();
      check("restart_valid", {31'b0, instr_valid}, 32'd1);
      check("restart_word", instr, 32'h8C00_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
